// File: rtl/dm_sba_ctrl_pkg.sv
// Shared types for the debug-module system bus access controller.
// No logic: FSM state encoding, sberror codes and a sizing helper.
// No backpressure: definitions only.
package dm_sba_ctrl_pkg;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    Write     = 3'd2,
    WaitRead  = 3'd3,
    WaitWrite = 3'd4
  } sba_state_e;

  typedef enum logic [2:0] {
    SbErrNone    = 3'd0,
    SbErrTimeout = 3'd1,
    SbErrBadAddr = 3'd2,
    SbErrAlign   = 3'd3,
    SbErrSize    = 3'd4,
    SbErrOther   = 3'd7
  } sb_err_e;

  // Bytes moved by one access of the given sbaccess code.
  function automatic logic [7:0] access_bytes(input logic [2:0] sbaccess);
    return 8'd1 << sbaccess;
  endfunction

endpackage

// File: rtl/dm_sba_ctrl.sv
// System bus access engine: turns sbaddress/sbdata strobes into single bus transfers.
// Latency: request one cycle after the strobe; sbbusy_o drops the cycle after rvalid_i.
// Backpressure: req_o held until gnt_i; strobes while busy are dropped and flag sbbusyerror_o.
module dm_sba_ctrl
  import dm_sba_ctrl_pkg::*;
#(
  parameter int unsigned BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sberror_clear_i,
  input  logic [0:0]            sbbusyerror_clear_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic [2:0]            sberror_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [BusWidth-1:0]   rdata_i,
  input  logic                  rerr_i
);

  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam logic [BusWidth-1:0] One      = {{(BusWidth-1){1'b0}}, 1'b1};
  localparam logic [BusWidth-1:0] LaneMask = (One << OffW) - One;

  sba_state_e            state_q;
  logic [BusWidth-1:0]   sbaddress_q, sbdata_q, addr_q, wdata_q;
  logic [NumBytes-1:0]   be_q;
  logic [2:0]            sberror_q;
  logic                  sbbusyerror_q, req_q, we_q;
  logic [OffW-1:0]       off_q;
  logic [2:0]            acc_q;

  logic                  busy, strobe_any, start_rd, start_wr, can_start;
  logic                  size_err, align_err;
  logic [31:0]           size_bits;
  logic [BusWidth-1:0]   acc_addr, align_mask, wdata_d, rdata_d, rmask, addr_inc;
  logic [OffW-1:0]       acc_off;
  logic [7:0]            acc_bytes;
  logic [NumBytes-1:0]   lane_mask, be_d;
  logic [10:0]           rbits;

  assign busy       = (state_q != Idle);
  assign strobe_any = sbaddress_write_valid_i | sbdata_write_valid_i | sbdata_read_valid_i;
  assign start_wr   = sbdata_write_valid_i;
  assign start_rd   = (sbaddress_write_valid_i & sbreadonaddr_i) |
                      (sbdata_read_valid_i & sbreadondata_i);
  assign can_start  = (sberror_q == SbErrNone) && !sbbusyerror_q;

  // A read-on-address access targets the address being written this cycle.
  assign acc_addr   = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
  assign acc_off    = acc_addr[OffW-1:0];
  assign acc_bytes  = access_bytes(sbaccess_i);

  assign size_bits  = 32'd8 << sbaccess_i;
  assign size_err   = size_bits > BusWidth;
  assign align_mask = (One << sbaccess_i) - One;
  assign align_err  = |(acc_addr & align_mask);

  // Byte lanes never spill past the bus because the access is aligned by then.
  assign lane_mask  = ~({NumBytes{1'b1}} << acc_bytes);
  assign be_d       = lane_mask << acc_off;
  assign wdata_d    = sbdata_i << {acc_off, 3'b000};

  assign rbits      = 11'd8 << acc_q;
  assign rmask      = ~({BusWidth{1'b1}} << rbits);
  assign rdata_d    = (rdata_i >> {off_q, 3'b000}) & rmask;
  assign addr_inc   = sbaddress_q + (One << sbaccess_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || !dmactive_i) begin
      state_q       <= Idle;
      sbaddress_q   <= '0;
      sbdata_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      sberror_q     <= SbErrNone;
      sbbusyerror_q <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      off_q         <= '0;
      acc_q         <= '0;
    end else begin
      sberror_q <= sberror_q & ~sberror_clear_i;
      if (sbbusyerror_clear_i[0]) sbbusyerror_q <= 1'b0;

      case (state_q)
        Idle: begin
          if (sbaddress_write_valid_i) sbaddress_q <= sbaddress_i;
          if (sbdata_write_valid_i)    sbdata_q    <= sbdata_i;
          if ((start_rd || start_wr) && can_start) begin
            if (size_err) begin
              sberror_q <= SbErrSize;
            end else if (align_err) begin
              sberror_q <= SbErrAlign;
            end else begin
              state_q <= start_wr ? Write : Read;
              req_q   <= 1'b1;
              we_q    <= start_wr;
              addr_q  <= acc_addr & ~LaneMask;
              be_q    <= be_d;
              off_q   <= acc_off;
              acc_q   <= sbaccess_i;
              if (start_wr) wdata_q <= wdata_d;
            end
          end
        end
        Read, Write: begin
          if (gnt_i) begin
            req_q   <= 1'b0;
            state_q <= (state_q == Write) ? WaitWrite : WaitRead;
          end
        end
        WaitRead, WaitWrite: begin
          if (rvalid_i) begin
            state_q <= Idle;
            we_q    <= 1'b0;
            be_q    <= '0;
            if (rerr_i) begin
              sberror_q <= SbErrBadAddr;
            end else begin
              if (state_q == WaitRead) sbdata_q <= rdata_d;
              if (sbautoincrement_i)   sbaddress_q <= addr_inc;
            end
          end
        end
        default: state_q <= Idle;
      endcase

      // Placed last so a strobe while busy wins over a same-cycle clear.
      if (busy && strobe_any) sbbusyerror_q <= 1'b1;
    end
  end

  assign sbaddress_o   = sbaddress_q;
  assign sbdata_o      = sbdata_q;
  assign sbbusy_o      = busy;
  assign sbbusyerror_o = sbbusyerror_q;
  assign sberror_o     = sberror_q;
  assign req_o         = req_q;
  assign we_o          = we_q;
  assign addr_o        = addr_q;
  assign wdata_o       = wdata_q;
  assign be_o          = be_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Bench for dm_sba_ctrl: a 32-bit and a 64-bit instance share stimulus, selected by sel.
module tb_dm_sba_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1, dmactive = 1'b1;
  logic [63:0] sbaddress = '0, sbdata = '0, rdata = '0;
  logic        aw = 0, dw = 0, dr = 0;
  logic [2:0]  acc = '0;
  logic        roa = 0, rod = 0, autoinc = 0;
  logic [2:0]  errclr = '0;
  logic [0:0]  bclr = '0;
  logic        gnt = 0, rvalid = 0, rerr = 0;
  int          sel = 0;

  int checks = 0, errors = 0;
  logic [63:0] m_addr, m_data;
  logic [2:0]  m_err;
  logic        m_berr;
  logic [63:0] cap_addr, cap_be, cap_wdata;

  always #5 clk = ~clk;

  logic [31:0] a32, d32, ao32, wd32;
  logic [3:0]  be32;
  logic [2:0]  e32;
  logic        b32, be_err32, req32, we32;
  logic [63:0] a64, d64, ao64, wd64;
  logic [7:0]  be64;
  logic [2:0]  e64;
  logic        b64, be_err64, req64, we64;

  dm_sba_ctrl #(.BusWidth(32)) u32 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .sbaddress_i(sbaddress[31:0]), .sbaddress_write_valid_i(aw && sel == 0),
    .sbdata_i(sbdata[31:0]), .sbdata_write_valid_i(dw && sel == 0),
    .sbdata_read_valid_i(dr && sel == 0),
    .sbaccess_i(acc), .sbreadonaddr_i(roa), .sbreadondata_i(rod), .sbautoincrement_i(autoinc),
    .sberror_clear_i(errclr), .sbbusyerror_clear_i(bclr),
    .sbaddress_o(a32), .sbdata_o(d32), .sbbusy_o(b32), .sbbusyerror_o(be_err32), .sberror_o(e32),
    .req_o(req32), .we_o(we32), .addr_o(ao32), .wdata_o(wd32), .be_o(be32),
    .gnt_i(gnt && sel == 0), .rvalid_i(rvalid && sel == 0), .rdata_i(rdata[31:0]), .rerr_i(rerr));

  dm_sba_ctrl #(.BusWidth(64)) u64 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .sbaddress_i(sbaddress), .sbaddress_write_valid_i(aw && sel == 1),
    .sbdata_i(sbdata), .sbdata_write_valid_i(dw && sel == 1),
    .sbdata_read_valid_i(dr && sel == 1),
    .sbaccess_i(acc), .sbreadonaddr_i(roa), .sbreadondata_i(rod), .sbautoincrement_i(autoinc),
    .sberror_clear_i(errclr), .sbbusyerror_clear_i(bclr),
    .sbaddress_o(a64), .sbdata_o(d64), .sbbusy_o(b64), .sbbusyerror_o(be_err64), .sberror_o(e64),
    .req_o(req64), .we_o(we64), .addr_o(ao64), .wdata_o(wd64), .be_o(be64),
    .gnt_i(gnt && sel == 1), .rvalid_i(rvalid && sel == 1), .rdata_i(rdata), .rerr_i(rerr));

  wire [63:0] o_addr  = sel ? a64  : {32'h0, a32};
  wire [63:0] o_data  = sel ? d64  : {32'h0, d32};
  wire [63:0] o_aout  = sel ? ao64 : {32'h0, ao32};
  wire [63:0] o_wdata = sel ? wd64 : {32'h0, wd32};
  wire [63:0] o_be    = sel ? {56'h0, be64} : {60'h0, be32};
  wire [2:0]  o_err   = sel ? e64 : e32;
  wire        o_busy  = sel ? b64 : b32;
  wire        o_berr  = sel ? be_err64 : be_err32;
  wire        o_req   = sel ? req64 : req32;
  wire        o_we    = sel ? we64 : we32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_sbaddress"}, o_addr, m_addr);
    chk({tag, "_sbdata"}, o_data, m_data);
    chk({tag, "_sberror"}, {61'h0, o_err}, {61'h0, m_err});
    chk({tag, "_sbbusyerror"}, {63'h0, o_berr}, {63'h0, m_berr});
    chk({tag, "_sbbusy"}, {63'h0, o_busy}, 64'h0);
  endtask

  task automatic model_zero();
    m_addr = '0; m_data = '0; m_err = '0; m_berr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_regs(tag);
    chk({tag, "_req"}, {63'h0, o_req}, 64'h0);
    chk({tag, "_we"}, {63'h0, o_we}, 64'h0);
    chk({tag, "_be"}, o_be, 64'h0);
  endtask

  task automatic reset_all(input bit use_dmactive);
    if (use_dmactive) dmactive = 1'b0; else rst = 1'b1;
    step();
    step();
    rst = 1'b0; dmactive = 1'b1;
    model_zero();
    check_zero("reset");
  endtask

  task automatic clear(input logic [2:0] e, input logic b);
    errclr = e; bclr = b;
    step();
    errclr = '0; bclr = '0;
    m_err = m_err & ~e;
    if (b) m_berr = 1'b0;
    check_regs("clear");
  endtask

  // kind: 0 = sbdata write, 1 = sbaddress write, 2 = sbdata read
  task automatic run_op(input int kind, input logic [63:0] val, input logic [63:0] rd,
                        input bit re, input bit poke, input bit rst_mid);
    int bw, nbytes, size, off;
    logic [63:0] bwmask, a, exp_be, exp_wdata, dmask;
    bit want, go, is_wr;
    bw = sel ? 64 : 32;
    nbytes = bw / 8;
    bwmask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    is_wr = (kind == 0);
    want = is_wr || (kind == 1 && roa) || (kind == 2 && rod);
    go = want && m_err == 0 && !m_berr;
    if (kind == 1) m_addr = val & bwmask;
    if (kind == 0) m_data = val & bwmask;
    a = m_addr;
    if (go) begin
      if ((8 << acc) > bw) begin m_err = 3'd4; go = 0; end
      else if ((a % (64'd1 << acc)) != 0) begin m_err = 3'd3; go = 0; end
    end
    case (kind)
      0: begin sbdata = val; dw = 1'b1; end
      1: begin sbaddress = val; aw = 1'b1; end
      default: dr = 1'b1;
    endcase
    step();
    aw = 0; dw = 0; dr = 0;
    if (!go) begin
      chk("noreq", {63'h0, o_req}, 64'h0);
      check_regs("nostart");
      return;
    end
    size = 1 << acc;
    off = int'(a % nbytes);
    exp_be = ((64'd1 << size) - 1) << off;
    exp_wdata = (m_data << (8 * off)) & bwmask;
    chk("req", {63'h0, o_req}, 64'h1);
    chk("busy", {63'h0, o_busy}, 64'h1);
    chk("addr_o", o_aout, a - off);
    chk("be_o", o_be, exp_be);
    chk("we_o", {63'h0, o_we}, {63'h0, is_wr});
    if (is_wr) chk("wdata_o", o_wdata, exp_wdata);
    cap_addr = o_aout; cap_be = o_be; cap_wdata = o_wdata;
    repeat ($urandom_range(0, 3)) step();
    chk("req_hold", {63'h0, o_req}, 64'h1);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("req_drop", {63'h0, o_req}, 64'h0);
    chk("busy_wait", {63'h0, o_busy}, 64'h1);
    if (poke) begin
      sbdata = ~val; dw = 1'b1;
      step();
      dw = 1'b0;
      m_berr = 1'b1;
      chk("poke_berr", {63'h0, o_berr}, 64'h1);
      chk("poke_sbdata", o_data, m_data);
      if (is_wr) chk("poke_wdata", o_wdata, exp_wdata);
    end
    repeat ($urandom_range(0, 3)) step();
    if (rst_mid) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_zero();
      rvalid = 1'b1; rdata = rd;
      step();
      rvalid = 1'b0;
      check_zero("rst_mid");
      return;
    end
    rvalid = 1'b1; rdata = rd; rerr = re;
    step();
    rvalid = 1'b0; rerr = 1'b0;
    if (re) m_err = 3'd2;
    else begin
      if (!is_wr) begin
        dmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 1);
        m_data = (rd >> (8 * off)) & dmask;
      end
      if (autoinc) m_addr = (a + size) & bwmask;
    end
    check_regs("done");
  endtask

  initial begin
    model_zero();
    sel = 0;
    reset_all(0);

    // 32-bit halfword write at byte offset 2
    acc = 3'd1; roa = 0; rod = 0; autoinc = 0;
    run_op(1, 64'h1002, 0, 0, 0, 0);
    run_op(0, 64'hABCD, 0, 0, 0, 0);
    chk("hw_wdata", cap_wdata, 64'hABCD_0000);
    chk("hw_be", cap_be, 64'hC);
    chk("hw_addr", cap_addr, 64'h1000);

    // Size error beats alignment, then alignment error
    acc = 3'd3;
    run_op(0, 64'h55, 0, 0, 0, 0);
    chk("size_err", {61'h0, o_err}, 64'h4);
    clear(3'h7, 1'b0);
    acc = 3'd1;
    run_op(1, 64'h3, 0, 0, 0, 0);
    run_op(0, 64'h66, 0, 0, 0, 0);
    chk("align_err", {61'h0, o_err}, 64'h3);

    // Error blocks start but address still updates; clear wins over simultaneous start
    acc = 3'd2;
    run_op(1, 64'h20, 0, 0, 0, 0);
    errclr = 3'h7; sbdata = 64'h77; dw = 1'b1;
    step();
    errclr = '0; dw = 1'b0;
    m_err = '0; m_data = 64'h77;
    chk("clr_nostart", {63'h0, o_busy}, 64'h0);
    check_regs("clr_first");
    run_op(0, 64'h77, 0, 0, 0, 0);

    // Busy-error while WaitWrite, then clear and proceed
    run_op(1, 64'h40, 0, 0, 0, 0);
    run_op(0, 64'h1234_5678, 0, 0, 1, 0);
    run_op(0, 64'h9999, 0, 0, 0, 0);
    chk("berr_blocks", {63'h0, o_berr}, 64'h1);
    clear(3'h0, 1'b1);
    run_op(0, 64'h9999, 0, 0, 0, 0);

    // Read bus error: no increment; reset mid-WaitRead drops the response
    autoinc = 1; roa = 1;
    run_op(1, 64'h200, 64'hDEAD_BEEF, 1, 0, 0);
    chk("rerr_code", {61'h0, o_err}, 64'h2);
    chk("rerr_noinc", o_addr, 64'h200);
    clear(3'h7, 1'b0);
    run_op(1, 64'h300, 64'hCAFE_F00D, 0, 0, 1);

    // Autoincrementing reads-on-data, plus address wrap
    reset_all(1);
    roa = 0; rod = 1; autoinc = 1; acc = 3'd2;
    run_op(1, 64'h100, 0, 0, 0, 0);
    run_op(2, 0, 64'h1111_1111, 0, 0, 0);
    chk("ai_addr0", cap_addr, 64'h100);
    run_op(2, 0, 64'h2222_2222, 0, 0, 0);
    chk("ai_addr1", cap_addr, 64'h104);
    run_op(2, 0, 64'h3333_3333, 0, 0, 0);
    chk("ai_addr2", cap_addr, 64'h108);
    chk("ai_final", o_addr, 64'h10C);
    run_op(1, 64'hFFFF_FFFC, 0, 0, 0, 0);
    run_op(2, 0, 64'h4444_4444, 0, 0, 0);
    chk("ai_wrap", o_addr, 64'h0);

    // 64-bit read-on-address of the upper word
    sel = 1;
    reset_all(0);
    roa = 1; rod = 0; autoinc = 0; acc = 3'd2;
    run_op(1, 64'h8004, 64'h1122_3344_5566_7788, 0, 0, 0);
    chk("rd64_data", o_data, 64'h1122_3344);
    chk("rd64_be", cap_be, 64'hF0);

    // Randomized traffic on both widths
    for (int s = 0; s < 2; s++) begin
      sel = s;
      reset_all(0);
      for (int n = 0; n < 40; n++) begin
        acc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        roa = 1'($urandom); rod = 1'($urandom); autoinc = 1'($urandom);
        run_op($urandom_range(0, 2), {$urandom, $urandom} & 64'h0000_FFFF_0000_FFFF,
               {$urandom, $urandom}, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, 0);
        if ((m_err != 0 || m_berr) && $urandom_range(0, 1) == 1) clear(3'h7, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_sba_ctrl.md
DM_SBA_CTRL -- requirements
Module: dm_sba_ctrl

Interface
REQ-001 SHALL have parameter BusWidth, default 32, system bus data/address width; legal values are 32 and 64.
REQ-002 SHALL have clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have dmactive_i  input  1  low forces the same state as rst_i, on the next edge.
REQ-005 SHALL have sbaddress_i / sbaddress_write_valid_i  input  BusWidth / 1  new sbaddress value and its write strobe.
REQ-006 SHALL have sbdata_i / sbdata_write_valid_i / sbdata_read_valid_i  input  BusWidth / 1 / 1  sbdata write value and strobe, and the sbdata read strobe.
REQ-007 SHALL have sbaccess_i, sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  input  3/1/1/1  sbcs configuration fields.
REQ-008 SHALL have sberror_clear_i [2:0], sbbusyerror_clear_i [0:0]  input  write-1-to-clear masks from an sbcs write.
REQ-009 SHALL have sbaddress_o, sbdata_o  output  BusWidth  current address and read-data registers.
REQ-010 SHALL have sbbusy_o, sbbusyerror_o, sberror_o  output  1/1/3  sbcs status fields.
REQ-011 SHALL have req_o, we_o, addr_o[BusWidth], wdata_o[BusWidth], be_o[BusWidth/8]  output  bus request.
REQ-012 SHALL have gnt_i, rvalid_i, rdata_i[BusWidth], rerr_i  input  bus grant and response.

Function
REQ-013 SHALL use the FSM states Idle, Read, Write, WaitRead and WaitWrite; sbbusy_o SHALL be high in every state except Idle.
REQ-014 SHALL start a read from Idle on sbaddress_write_valid_i with sbreadonaddr_i=1, or on sbdata_read_valid_i with sbreadondata_i=1.
REQ-015 SHALL start a write from Idle on sbdata_write_valid_i.
REQ-016 SHALL start no transfer while sberror_o!=0 or sbbusyerror_o=1; register writes still update.
REQ-017 SHALL, when any strobe of REQ-005/006 arrives while sbbusy_o=1, set sbbusyerror_o and ignore that strobe entirely.
REQ-018 SHALL hold req_o high in Read/Write until gnt_i; on grant it SHALL move to WaitRead/WaitWrite, and on rvalid_i it SHALL return to Idle.
REQ-019 SHALL set sberror_o=4 with no bus request when 8<<sbaccess_i exceeds BusWidth; this check SHALL take priority over alignment.
REQ-020 SHALL set sberror_o=3 with no bus request when sbaddress_o is not a multiple of 1<<sbaccess_i.
REQ-021 SHALL drive addr_o as sbaddress_o aligned down to BusWidth/8 bytes.
REQ-022 SHALL set in be_o the 1<<sbaccess bits starting at the byte offset.
REQ-023 SHALL drive wdata_o as sbdata shifted left by offset*8.
REQ-024 SHALL load on read rvalid_i: sbdata_o = (rdata_i >> offset*8), with bits above the access size zeroed.
REQ-025 SHALL, on rvalid_i with rerr_i=1, set sberror_o=2, leave sbdata_o unchanged, and suppress autoincrement.
REQ-026 SHALL add 1<<sbaccess_i to sbaddress_o on successful completion when sbautoincrement_i=1; the addition SHALL wrap modulo 2^BusWidth.
REQ-027 SHALL latch sbaddress_i on a read-on-address start and use it for that access.
REQ-028 SHALL give a simultaneous start and clear to the clear; the transfer SHALL then start in the next cycle if the strobe is still held.
REQ-029 SHALL complete a transfer with latency gnt cycle + 1, after which sbbusy_o falls on the cycle following rvalid_i.
REQ-030 SHALL accept a strobe arriving on the same cycle sbbusy_o falls as a new transfer.

Reset
REQ-031 SHALL on rst_i or !dmactive_i go to Idle and clear sbaddress_o, sbdata_o, sberror_o, sbbusyerror_o, req_o, we_o and be_o to 0.
REQ-032 SHALL, on reset during WaitRead/WaitWrite, drop the outstanding response: an rvalid_i after reset has no effect.

Structure
REQ-033 SHALL take its FSM state enum and SbErr constants (None=0, Timeout=1, BadAddr=2, Align=3, Size=4, Other=7) from the dm package.
REQ-034 SHALL have no sub-module; the byte-lane shift/mask logic SHALL be written inline.

Verification
REQ-035 SHALL cover: BusWidth=32, addr 0x1002, sbaccess=1, write sbdata 0xABCD -> wdata 0xABCD0000, be 0b1100, then sbbusy_o low.
REQ-036 SHALL cover: BusWidth=64, readonaddr, addr 0x8004, sbaccess=2, rdata 0x11223344_55667788 -> sbdata_o 0x11223344.
REQ-037 SHALL cover: autoincrement with sbaccess=2, three readondata reads from 0x100 -> addresses 0x100, 0x104, 0x108; final sbaddress_o 0x10C.
REQ-038 SHALL cover: BusWidth=32, sbaccess=3 write -> sberror_o=4 and no req_o; then addr 0x3, sbaccess=1 -> sberror_o=3.
REQ-039 SHALL cover: a sbdata write during WaitWrite -> sbbusyerror_o=1, wdata unchanged; after clear with 1, the next write proceeds.
REQ-040 SHALL cover: rerr_i on a read -> sberror_o=2, address not incremented; rst_i mid-WaitRead -> Idle with all outputs zero.
